rf_wb_scheduler: RTL and testbench

Write-back scheduler and hazard scoreboard for the shared scalar/vector register file. It merges two write-back requesters, execute (0) and memory (1), onto the register file's single write port, using round-robin arbitration and a registered output stage. It also tracks pending destination registers so that the issue stage stalls on RAW and WAW hazards.

---
 rtl/rf_ctrl_pkg.sv | 22 ++
 rtl/rf_wb_scheduler_if.sv | 31 +++
 rtl/rf_scoreboard.sv | 85 ++++++++
 rtl/rf_wb_scheduler.sv | 91 +++++++++
 tb/tb_rf_wb_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types and helpers for the register-file write-back path.
// Lane 15 of a vector write carries scalar data.
package rf_ctrl_pkg;

  localparam int LANES = 16;
  localparam int XLEN  = 32;

  localparam logic [2:0] CMD_VTOS = 3'b101;
  localparam logic [3:0] PC_IDX   = 4'hF;

  typedef logic [LANES-1:0][XLEN-1:0] vreg_t;
  typedef logic [3:0] reg_idx_t;

  // Vector write-select with the vtos command still lands in a scalar reg.
  function automatic logic is_scalar(
    input logic       sel,
    input logic [2:0] cmd
  );
    return ~sel | (cmd == CMD_VTOS);
  endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Two-requester write-back bus: index 0 is execute, index 1 is memory.
// A requester holds its request until it sees its ready bit.
interface rf_wb_scheduler_if;
  import rf_ctrl_pkg::*;

  logic [1:0]      wb_valid;
  logic [1:0]      wb_ready;
  reg_idx_t [1:0]  wb_addr;
  logic [1:0]      wb_vec;
  logic [1:0][2:0] wb_cmd;
  vreg_t [1:0]     wb_data;

  modport master (
    output wb_valid,
    output wb_addr,
    output wb_vec,
    output wb_cmd,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_addr,
    input  wb_vec,
    input  wb_cmd,
    input  wb_data,
    output wb_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination tracker: RAW/WAW stall, reserve on issue,
// release on write-back grant, sticky error on unreserved release.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       iss_valid,
  input  reg_idx_t   iss_rs1,
  input  reg_idx_t   iss_rs2,
  input  logic       iss_rs1_v,
  input  logic       iss_rs2_v,
  input  reg_idx_t   iss_rd,
  input  logic       iss_rd_v,
  input  logic [2:0] iss_rd_cmd,
  input  logic       iss_rd_we,
  output logic       iss_stall,
  input  logic       clr_en,
  input  reg_idx_t   clr_idx,
  input  logic       clr_s,
  output logic       sb_err
);

  logic [15:0] busy_s;
  logic [15:0] busy_v;
  logic [15:0] set_s;
  logic [15:0] set_v;
  logic [15:0] clr_sm;
  logic [15:0] clr_vm;
  logic        rd_s;
  logic        rsv;
  logic        clr_hit;

  // The PC alias is never reported busy.
  function automatic logic hit(
    input logic [15:0] bs,
    input logic [15:0] bv,
    input reg_idx_t    i,
    input logic        s
  );
    return s ? (bs[i] & (i != PC_IDX)) : bv[i];
  endfunction

  // Hazard detection and per-bit set/clear masks.
  always_comb begin
    rd_s      = is_scalar(iss_rd_v, iss_rd_cmd);
    iss_stall = iss_valid & (
      hit(busy_s, busy_v, iss_rs1, ~iss_rs1_v) |
      hit(busy_s, busy_v, iss_rs2, ~iss_rs2_v) |
      (iss_rd_we & hit(busy_s, busy_v, iss_rd, rd_s)));
    rsv     = iss_valid & ~iss_stall & iss_rd_we;
    set_s   = '0;
    set_v   = '0;
    clr_sm  = '0;
    clr_vm  = '0;
    if (rsv) begin
      if (!rd_s)
        set_v[iss_rd] = 1'b1;
      else if (iss_rd != PC_IDX)
        set_s[iss_rd] = 1'b1;
    end
    if (clr_en) begin
      if (clr_s)
        clr_sm[clr_idx] = 1'b1;
      else
        clr_vm[clr_idx] = 1'b1;
    end
    clr_hit = hit(busy_s, busy_v, clr_idx, clr_s);
  end

  // Busy update: a same-edge reserve overrides the release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s <= '0;
      busy_v <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_s <= (busy_s & ~clr_sm) | set_s;
      busy_v <= (busy_v & ~clr_vm) | set_v;
      if (clr_en && !clr_hit)
        sb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin merge of execute/memory write-backs onto one registered
// register-file write port, plus the issue hazard scoreboard.
module rf_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  reg_idx_t         iss_rs1,
  input  reg_idx_t         iss_rs2,
  input  logic             iss_rs1_v,
  input  logic             iss_rs2_v,
  input  reg_idx_t         iss_rd,
  input  logic             iss_rd_v,
  input  logic [2:0]       iss_rd_cmd,
  input  logic             iss_rd_we,
  output logic             iss_stall,
  rf_wb_scheduler_if.slave wb,
  output logic             rf_we,
  output reg_idx_t         rf_wa,
  output logic             rf_sel_w,
  output logic [2:0]       rf_cmd,
  output vreg_t            rf_wd,
  output logic             sb_err,
  output logic [CNT_W-1:0] wb_conflicts
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0] gnt;
  logic       gnt_en;
  logic       sel;
  logic       rr_ptr;

  // Single valid wins outright; on contention rr_ptr picks.
  always_comb begin
    gnt = wb.wb_valid;
    if (&wb.wb_valid)
      gnt = rr_ptr ? 2'b10 : 2'b01;
  end

  assign wb.wb_ready = gnt;
  assign gnt_en      = |gnt;
  assign sel         = gnt[1];

  // Output stage, round-robin pointer and saturating contention count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_wa        <= '0;
      rf_sel_w     <= 1'b0;
      rf_cmd       <= '0;
      rf_wd        <= '0;
      rr_ptr       <= 1'b0;
      wb_conflicts <= '0;
    end else begin
      rf_we <= gnt_en;
      if (gnt_en) begin
        rf_wa    <= wb.wb_addr[sel];
        rf_sel_w <= wb.wb_vec[sel];
        rf_cmd   <= wb.wb_cmd[sel];
        rf_wd    <= wb.wb_data[sel];
        rr_ptr   <= ~sel;
      end
      if (&wb.wb_valid && !(&wb_conflicts))
        wb_conflicts <= wb_conflicts + ONE;
    end
  end

  rf_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_rs1_v  (iss_rs1_v),
    .iss_rs2_v  (iss_rs2_v),
    .iss_rd     (iss_rd),
    .iss_rd_v   (iss_rd_v),
    .iss_rd_cmd (iss_rd_cmd),
    .iss_rd_we  (iss_rd_we),
    .iss_stall  (iss_stall),
    .clr_en     (gnt_en),
    .clr_idx    (wb.wb_addr[sel]),
    .clr_s      (is_scalar(wb.wb_vec[sel], wb.wb_cmd[sel])),
    .sb_err     (sb_err)
  );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: arbiter model feeds an expected-write
// queue that is drained against the registered write port.
module tb_rf_wb_scheduler;
  import rf_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iss_valid;
  reg_idx_t    iss_rs1;
  reg_idx_t    iss_rs2;
  logic        iss_rs1_v;
  logic        iss_rs2_v;
  reg_idx_t    iss_rd;
  logic        iss_rd_v;
  logic [2:0]  iss_rd_cmd;
  logic        iss_rd_we;
  logic        iss_stall;
  logic        rf_we;
  reg_idx_t    rf_wa;
  logic        rf_sel_w;
  logic [2:0]  rf_cmd;
  vreg_t       rf_wd;
  logic        sb_err;
  logic [15:0] wb_conflicts;

  rf_wb_scheduler_if wbi();

  always #5 clk = ~clk;

  rf_wb_scheduler #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rs1_v    (iss_rs1_v),
    .iss_rs2_v    (iss_rs2_v),
    .iss_rd       (iss_rd),
    .iss_rd_v     (iss_rd_v),
    .iss_rd_cmd   (iss_rd_cmd),
    .iss_rd_we    (iss_rd_we),
    .iss_stall    (iss_stall),
    .wb           (wbi),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_sel_w     (rf_sel_w),
    .rf_cmd       (rf_cmd),
    .rf_wd        (rf_wd),
    .sb_err       (sb_err),
    .wb_conflicts (wb_conflicts)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string        tag,
    input logic [511:0] got,
    input logic [511:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic vreg_t rnd_v();
    vreg_t v;
    for (int l = 0; l < LANES; l++)
      v[l] = $urandom;
    return v;
  endfunction

  typedef struct {
    reg_idx_t   a;
    logic       v;
    logic [2:0] c;
    vreg_t      d;
  } wr_t;

  wr_t  q[$];
  wr_t  e;
  bit   mptr;
  int   mcnt;
  logic [1:0] g;
  int   gi;

  // Reference arbiter and output-port scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mptr = 1'b0;
      mcnt = 0;
    end else begin
      chk("rf_we", rf_we, q.size() != 0);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rf_wa", rf_wa, e.a);
        chk("rf_sel_w", rf_sel_w, e.v);
        chk("rf_cmd", rf_cmd, e.c);
        chk("rf_wd", rf_wd, e.d);
      end
      chk("conflicts", wb_conflicts, mcnt);
      if (&wbi.wb_valid && mcnt < 65535)
        mcnt++;
      g = wbi.wb_valid;
      if (&wbi.wb_valid)
        g = mptr ? 2'b10 : 2'b01;
      chk("wb_ready", wbi.wb_ready, g);
      if (g != 2'b00) begin
        gi = g[1] ? 1 : 0;
        q.push_back('{wbi.wb_addr[gi], wbi.wb_vec[gi],
                      wbi.wb_cmd[gi], wbi.wb_data[gi]});
        mptr = (gi == 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(
    input logic     vld,
    input reg_idx_t rs1,
    input logic     rs1v,
    input reg_idx_t rs2,
    input logic     rs2v,
    input reg_idx_t rd,
    input logic     rdv,
    input logic [2:0] cmd,
    input logic     we
  );
    iss_valid  = vld;
    iss_rs1    = rs1;
    iss_rs1_v  = rs1v;
    iss_rs2    = rs2;
    iss_rs2_v  = rs2v;
    iss_rd     = rd;
    iss_rd_v   = rdv;
    iss_rd_cmd = cmd;
    iss_rd_we  = we;
  endtask

  task automatic wbq(
    input int         i,
    input reg_idx_t   a,
    input logic       v,
    input logic [2:0] c
  );
    wbi.wb_valid[i] = 1'b1;
    wbi.wb_addr[i]  = a;
    wbi.wb_vec[i]   = v;
    wbi.wb_cmd[i]   = c;
    wbi.wb_data[i]  = rnd_v();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wbi.wb_valid = 2'b00;
    iss_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    iss(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);
    wbi.wb_valid = 2'b00;
    wbi.wb_addr  = '0;
    wbi.wb_vec   = '0;
    wbi.wb_cmd   = '0;
    wbi.wb_data  = '0;
    do_reset();

    @(negedge clk);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_wa", rf_wa, 4'd0);
    chk("rst_sel", rf_sel_w, 1'b0);
    chk("rst_cmd", rf_cmd, 3'd0);
    chk("rst_wd", rf_wd, 512'd0);
    chk("rst_err", sb_err, 1'b0);
    chk("rst_cnt", wb_conflicts, 16'd0);

    // reserve v3
    cyc();
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd3, 1'b1, 3'd0, 1'b1);
    @(negedge clk);
    chk("iss_v3", iss_stall, 1'b0);

    cyc();
    iss(1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);
    wbq(0, 4'd3, 1'b1, 3'd0);
    @(negedge clk);
    chk("raw_v3", iss_stall, 1'b1);
    iss_rs1_v = 1'b0;
    #1 chk("s3_free", iss_stall, 1'b0);
    iss_rs1 = 4'd0;
    iss_rs1_v = 1'b1;
    iss_rd_we = 1'b1;
    iss_rd = 4'd3;
    #1 chk("waw_v3", iss_stall, 1'b1);
    iss(1'b1, 4'd3, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);

    cyc();
    wbi.wb_valid = 2'b00;
    @(negedge clk);
    chk("v3_clear", iss_stall, 1'b0);
    chk("wa_v3", rf_wa, 4'd3);
    chk("err_v3", sb_err, 1'b0);

    // vtos destination reserves scalar 5
    cyc();
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd5, 1'b1, CMD_VTOS, 1'b1);
    @(negedge clk);
    chk("iss_s5", iss_stall, 1'b0);

    cyc();
    iss(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);
    @(negedge clk);
    chk("raw_s5", iss_stall, 1'b1);
    iss_rs1_v = 1'b1;
    #1 chk("v5_free", iss_stall, 1'b0);
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd5, 1'b1, 3'd0, 1'b1);
    #1 chk("waw_v5", iss_stall, 1'b0);
    iss_rd_cmd = CMD_VTOS;
    #1 chk("waw_s5", iss_stall, 1'b1);
    iss_valid = 1'b0;

    cyc();
    iss(1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);
    wbq(1, 4'd5, 1'b1, CMD_VTOS);
    @(negedge clk);
    chk("s5_busy", iss_stall, 1'b1);

    cyc();
    wbi.wb_valid = 2'b00;
    @(negedge clk);
    chk("s5_clear", iss_stall, 1'b0);
    chk("err_s5", sb_err, 1'b0);

    // PC alias
    cyc();
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd15, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk("iss_pc", iss_stall, 1'b0);

    cyc();
    iss(1'b1, 4'd15, 1'b0, 4'd15, 1'b0, 4'd15, 1'b0, 3'd0, 1'b1);
    @(negedge clk);
    chk("pc_never", iss_stall, 1'b0);

    // write-back to unreserved s7
    cyc();
    iss_valid = 1'b0;
    wbq(0, 4'd7, 1'b0, 3'd0);
    @(negedge clk);
    chk("err_pre", sb_err, 1'b0);

    cyc();
    wbi.wb_valid = 2'b00;
    @(negedge clk);
    chk("err_set", sb_err, 1'b1);
    repeat (3) cyc();
    @(negedge clk);
    chk("err_sticky", sb_err, 1'b1);

    // reset with s2 reserved and a grant in flight
    cyc();
    iss(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd2, 1'b0, 3'd0, 1'b1);
    wbq(1, 4'd9, 1'b1, 3'd0);
    cyc();
    wbi.wb_valid = 2'b00;
    iss(1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 3'd0, 1'b0);
    #1 chk("inflight", rf_we, 1'b1);
    chk("s2_busy", iss_stall, 1'b1);
    rst = 1'b1;
    #1 chk("arst_we", rf_we, 1'b0);
    chk("arst_busy", iss_stall, 1'b0);
    chk("arst_err", sb_err, 1'b0);
    chk("arst_wa", rf_wa, 4'd0);
    cyc();
    rst = 1'b0;
    iss_valid = 1'b0;

    // contention alternates starting with requester 0
    for (int i = 0; i < 4; i++) begin
      cyc();
      wbq(0, 4'd1, 1'b1, 3'd0);
      wbq(1, 4'd2, 1'b1, 3'd0);
      @(negedge clk);
      chk("alt_rdy", wbi.wb_ready, (i % 2) ? 2'b10 : 2'b01);
    end
    cyc();
    wbi.wb_valid = 2'b00;
    @(negedge clk);
    chk("alt_cnt", wb_conflicts, 16'd4);
    chk("alt_wa", rf_wa, 4'd2);

    // saturation
    do_reset();
    wbq(0, 4'd4, 1'b1, 3'd0);
    wbq(1, 4'd6, 1'b0, 3'd0);
    repeat (70000) @(posedge clk);
    #1 wbi.wb_valid = 2'b00;
    @(negedge clk);
    chk("sat_cnt", wb_conflicts, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
